// File: rtl/display_page_ctrl.sv
// Shares a 4-digit seven-segment display between four debug sources.
// Debounced next/hold buttons, optional auto-rotation, registered page output.
module display_page_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEB_CNT = 1_000_000,
  parameter int unsigned ROT_CNT = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_next,
  input  logic             btn_hold,
  input  logic             auto_en,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [WIDTH-1:0] src3,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       page,
  output logic             held,
  output logic             page_pulse
);

  localparam int unsigned DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int unsigned ROT_W = (ROT_CNT > 1) ? $clog2(ROT_CNT) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_CNT - 1);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             run_c;
  logic             held_c;
  logic [1:0]       btn_raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       press_p;
  logic             next_p;
  logic             hold_p;
  logic [ROT_W-1:0] rot_cnt;
  logic             rot_tick_c;
  logic             adv_c;
  logic             adv_q;
  logic [WIDTH-1:0] src_sel_c;

  assign btn_raw = {btn_hold, btn_next};
  assign next_p  = press_p[0];
  assign hold_p  = press_p[1];

  // Two-flop synchronizer for both raw buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Per-button debouncer: accept a new level after DEB_CNT stable cycles, pulse on press
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [DEB_W-1:0] cnt;
    logic             lvl;
    logic             pulse;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt   <= '0;
        lvl   <= 1'b0;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (sync2[i] == lvl) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          cnt   <= '0;
          lvl   <= sync2[i];
          pulse <= sync2[i];
        end else begin
          cnt <= cnt + DEB_W'(1);
        end
      end
    end

    assign press_p[i] = pulse;
  end

  // Hold FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Hold FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (hold_p) state_nxt = HOLD;
      HOLD:    if (hold_p) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Hold FSM: state decode (flop-derived, glitch-free)
  always_comb begin
    run_c  = 1'b0;
    held_c = 1'b0;
    case (state)
      RUN:     run_c  = 1'b1;
      HOLD:    held_c = 1'b1;
      default: run_c  = 1'b1;
    endcase
  end

  assign held = held_c;

  assign rot_tick_c = run_c && auto_en && (rot_cnt == ROT_LAST);
  assign adv_c      = run_c && (next_p || rot_tick_c);

  // Rotation interval counter; paused in HOLD, restarted by a manual step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_cnt <= '0;
    end else if (!auto_en) begin
      rot_cnt <= '0;
    end else if (run_c) begin
      if (next_p || rot_tick_c) rot_cnt <= '0;
      else                      rot_cnt <= rot_cnt + ROT_W'(1);
    end
  end

  always_comb begin
    src_sel_c = src0;
    case (page)
      2'd1:    src_sel_c = src1;
      2'd2:    src_sel_c = src2;
      2'd3:    src_sel_c = src3;
      default: src_sel_c = src0;
    endcase
  end

  // Page, output register and page strobe aligned with the first new-page data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page       <= '0;
      adv_q      <= 1'b0;
      page_pulse <= 1'b0;
      data_out   <= '0;
    end else begin
      adv_q      <= adv_c;
      page_pulse <= adv_q;
      if (adv_c) page <= page + 2'd1;
      if (run_c) data_out <= src_sel_c;
    end
  end

endmodule
